// File: rtl/day_calc_sequencer_pkg.sv
// Shared types and constants for the day-of-year calculator sweep sequencer.
// Holds the FSM state type, the datapath widths and the non-leap month lengths.
package day_calc_pkg;

    localparam int DAY_W   = 6;
    localparam int MONTH_W = 4;
    localparam int DOY_W   = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [DAY_W-1:0] MONTH_LEN [12] = '{
        6'd31, 6'd28, 6'd31, 6'd30, 6'd31, 6'd30,
        6'd31, 6'd31, 6'd30, 6'd31, 6'd30, 6'd31
    };

endpackage

// File: rtl/day_calc_sequencer_if.sv
// Bus between the sequencer and the external day-of-year calculator.
// No handshake: the sequencer holds month/day stable for a whole settle window
// and samples the calculator result in the single cycle that follows it.
interface day_calc_sequencer_if;
    import day_calc_pkg::*;

    logic [DAY_W-1:0]   calc_dayOfMonth;
    logic [MONTH_W-1:0] calc_month;
    logic [DOY_W-1:0]   calc_dayOfYear;

    modport master (
        output calc_dayOfMonth,
        output calc_month,
        input  calc_dayOfYear
    );

    modport slave (
        input  calc_dayOfMonth,
        input  calc_month,
        output calc_dayOfYear
    );

endinterface

// File: rtl/day_calc_sequencer_month_length_lut.sv
// Combinational month-length lookup; February becomes 29 days in a leap year.
// Months outside 1..12 return 0.
module month_length_lut
    import day_calc_pkg::*;
(
    input  logic [MONTH_W-1:0] month,
    input  logic               leap,
    output logic [DAY_W-1:0]   length
);

    logic [MONTH_W-1:0] idx;

    always_comb begin
        length = '0;
        idx    = month - 4'd1;
        if (month >= 4'd1 && month <= 4'd12) begin
            length = MONTH_LEN[idx];
            if (month == 4'd2 && leap) begin
                length = 6'd29;
            end
        end
    end

endmodule

// File: rtl/day_calc_sequencer.sv
// Walks every date of one year into an external day-of-year calculator and
// counts results that disagree with a running ordinal counter.
module day_calc_sequencer
    import day_calc_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   leap_year,
    day_calc_sequencer_if.master   calc,
    output logic                   busy,
    output logic                   done,
    output logic [DOY_W-1:0]       error_count,
    output logic                   first_err_valid,
    output logic [DOY_W-1:0]       first_err_day,
    output state_t                 state_o
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t             state_q, state_d;
    logic [MONTH_W-1:0] month_q, month_d;
    logic [DAY_W-1:0]   day_q, day_d;
    logic [DOY_W-1:0]   exp_q, exp_d;
    logic [DOY_W-1:0]   err_q, err_d;
    logic               fev_q, fev_d;
    logic [DOY_W-1:0]   fed_q, fed_d;
    logic               leap_q, leap_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [DAY_W-1:0]   month_len;

    month_length_lut u_lut (
        .month  (month_q),
        .leap   (leap_q),
        .length (month_len)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            month_q <= 4'd1;
            day_q   <= 6'd1;
            exp_q   <= 9'd1;
            err_q   <= '0;
            fev_q   <= 1'b0;
            fed_q   <= '0;
            leap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            month_q <= month_d;
            day_q   <= day_d;
            exp_q   <= exp_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fed_q   <= fed_d;
            leap_q  <= leap_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        month_d = month_q;
        day_d   = day_q;
        exp_d   = exp_q;
        err_d   = err_q;
        fev_d   = fev_q;
        fed_d   = fed_q;
        leap_d  = leap_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    month_d = 4'd1;
                    day_d   = 6'd1;
                    exp_d   = 9'd1;
                    err_d   = '0;
                    fev_d   = 1'b0;
                    fed_d   = '0;
                    leap_d  = leap_year;
                    cnt_d   = SETTLE_LOAD;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            CHECK: begin
                if (calc.calc_dayOfYear != exp_q) begin
                    if (err_q != '1) begin
                        err_d = err_q + 9'd1;
                    end
                    if (!fev_q) begin
                        fev_d = 1'b1;
                        fed_d = exp_q;
                    end
                end
                // 12/31 is the last date; otherwise advance to the next one
                if (month_q == 4'd12 && day_q == 6'd31) begin
                    state_d = DONE;
                end else begin
                    exp_d   = exp_q + 9'd1;
                    cnt_d   = SETTLE_LOAD;
                    state_d = SETTLE;
                    if (day_q == month_len) begin
                        day_d   = 6'd1;
                        month_d = month_q + 4'd1;
                    end else begin
                        day_d = day_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign calc.calc_month      = month_q;
    assign calc.calc_dayOfMonth = day_q;
    assign busy                 = (state_q == SETTLE) || (state_q == CHECK);
    assign done                 = (state_q == DONE);
    assign error_count          = err_q;
    assign first_err_valid      = fev_q;
    assign first_err_day        = fed_q;
    assign state_o              = state_q;

endmodule

// File: tb/tb_day_calc_sequencer.sv
// Bench for day_calc_sequencer: a calendar-based calculator model (correct,
// fixed non-leap, or randomly corrupted) drives two sequencers (settle 1 and 3).
module tb_day_calc_sequencer;
    import day_calc_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic start1 = 1'b0, start3 = 1'b0;
    logic leap_year = 1'b0;

    day_calc_sequencer_if if1 ();
    day_calc_sequencer_if if3 ();

    logic       busy1, done1, fev1, busy3, done3, fev3;
    logic [8:0] err1, fed1, err3, fed3;
    state_t     st1, st3;

    day_calc_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .leap_year(leap_year), .calc(if1),
        .busy(busy1), .done(done1), .error_count(err1), .first_err_valid(fev1),
        .first_err_day(fed1), .state_o(st1)
    );

    day_calc_sequencer #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .leap_year(leap_year), .calc(if3),
        .busy(busy3), .done(done3), .error_count(err3), .first_err_valid(fev3),
        .first_err_day(fed3), .state_o(st3)
    );

    // calculator model: 0 = correct for the sweep year, 1 = always non-leap, 2 = corrupted days
    int  calc_mode  = 0;
    bit  sweep_leap = 1'b0;
    bit  bad [1:366];

    function automatic int mlen(int m, bit lp);
        int t [12];
        t = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m < 1 || m > 12) return 0;
        if (m == 2 && lp) return 29;
        return t[m-1];
    endfunction

    function automatic int calc_out(int m, int d);
        int doy;
        bit lp;
        if (m < 1 || m > 12) return 0;
        lp  = (calc_mode == 1) ? 1'b0 : sweep_leap;
        doy = d;
        for (int k = 1; k < m; k++) doy += mlen(k, lp);
        if (calc_mode == 2 && doy >= 1 && doy <= 366 && bad[doy]) doy = doy + 1;
        return doy;
    endfunction

    always_comb begin
        if1.calc_dayOfYear = 9'(calc_out(int'(if1.calc_month), int'(if1.calc_dayOfMonth)));
        if3.calc_dayOfYear = 9'(calc_out(int'(if3.calc_month), int'(if3.calc_dayOfMonth)));
    end

    // selected-DUT view
    bit         sel = 1'b0;
    logic [3:0] m_mon;
    logic [5:0] m_day;
    logic       m_busy, m_done, m_fev;
    logic [8:0] m_err, m_fed;
    state_t     m_st;
    assign m_mon  = sel ? if3.calc_month      : if1.calc_month;
    assign m_day  = sel ? if3.calc_dayOfMonth : if1.calc_dayOfMonth;
    assign m_busy = sel ? busy3 : busy1;
    assign m_done = sel ? done3 : done1;
    assign m_fev  = sel ? fev3  : fev1;
    assign m_err  = sel ? err3  : err1;
    assign m_fed  = sel ? fed3  : fed1;
    assign m_st   = sel ? st3   : st1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive_start(input logic v);
        if (sel) start3 = v; else start1 = v;
    endtask

    task automatic run_sweep(input bit use3, input bit lp, input int mode, input bit noise,
                             input string tag);
        int q_m [$];
        int q_d [$];
        int s, n, total, idx, mism, done_at, exp_err, exp_first;
        bit exp_fev, seen229;
        sel = use3; sweep_leap = lp; calc_mode = mode;
        s = use3 ? 3 : 1;
        exp_err = 0; exp_first = 0; exp_fev = 1'b0; seen229 = 1'b0;
        for (int m = 1; m <= 12; m++) begin
            for (int d = 1; d <= mlen(m, lp); d++) begin
                q_m.push_back(m);
                q_d.push_back(d);
                if (calc_out(m, d) != q_m.size()) begin
                    exp_err++;
                    if (!exp_fev) begin exp_fev = 1'b1; exp_first = q_m.size(); end
                end
            end
        end
        n = q_m.size();
        total = n * (s + 1);
        leap_year = lp;
        drive_start(1'b1);
        @(posedge clk); #1;
        drive_start(1'b0);
        check({tag, "_start_state"}, 32'(m_st), 32'(SETTLE));
        check({tag, "_start_err"}, 32'(m_err), 32'd0);
        mism = 0; done_at = -1;
        for (int k = 0; k <= total + 1 && done_at < 0; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (m_done) begin
                done_at = k;
            end else if (k < total) begin
                idx = k / (s + 1);
                if (int'(m_mon) != q_m[idx] || int'(m_day) != q_d[idx] || !m_busy) mism++;
                if (m_mon == 4'd2 && m_day == 6'd29) seen229 = 1'b1;
            end
            if (noise) begin
                leap_year = 1'($urandom_range(0, 1));
                drive_start(1'($urandom_range(0, 9) == 0));
            end
            if (noise && k == total - 1) drive_start(1'b1);
        end
        drive_start(1'b0);
        check({tag, "_done_cycle"}, 32'(done_at), 32'(total));
        check({tag, "_date_seq_mism"}, 32'(mism), 32'd0);
        check({tag, "_error_count"}, 32'(m_err), 32'(exp_err));
        check({tag, "_first_valid"}, 32'(m_fev), 32'(exp_fev));
        check({tag, "_first_day"}, 32'(m_fed), 32'(exp_first));
        check({tag, "_final_date"}, {20'd0, m_mon, 2'd0, m_day}, {20'd0, 4'd12, 2'd0, 6'd31});
        check({tag, "_busy_end"}, 32'(m_busy), 32'd0);
        if (lp) check({tag, "_saw_2_29"}, 32'(seen229), 32'd1);
        @(posedge clk); #1;
        check({tag, "_done_held"}, 32'(m_st), 32'(DONE));
    endtask

    initial begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("reset_state1", 32'(st1), 32'(IDLE));
        check("reset_state3", 32'(st3), 32'(IDLE));
        check("reset_date1", {if1.calc_month, if1.calc_dayOfMonth}, {4'd1, 6'd1});
        check("reset_flags1", {busy1, done1, fev1, err1, fed1}, 32'd0);

        run_sweep(1'b0, 1'b0, 0, 1'b0, "nonleap");
        run_sweep(1'b0, 1'b1, 0, 1'b0, "leap");
        run_sweep(1'b0, 1'b1, 1, 1'b0, "leap_vs_fixed");
        check("fixed_first_err_day", 32'(fed1), 32'd61);
        check("fixed_error_count", 32'(err1), 32'd306);
        run_sweep(1'b0, 1'b0, 0, 1'b1, "noisy");

        for (int r = 0; r < 2; r++) begin
            for (int d = 1; d <= 366; d++) bad[d] = ($urandom_range(0, 19) == 0);
            run_sweep(1'b0, 1'($urandom_range(0, 1)), 2, 1'b0, $sformatf("rand%0d", r));
        end

        // abort a sweep on 6/15 after some errors have accumulated
        for (int d = 1; d <= 366; d++) bad[d] = 1'b0;
        bad[10] = 1'b1; bad[40] = 1'b1;
        sel = 1'b0; calc_mode = 2; sweep_leap = 1'b0; leap_year = 1'b0;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        begin
            int waited;
            waited = 0;
            while (!(if1.calc_month == 4'd6 && if1.calc_dayOfMonth == 6'd15) && waited < 1000) begin
                @(posedge clk); #1;
                waited++;
            end
            check("reach_6_15", 32'(waited < 1000), 32'd1);
        end
        check("pre_reset_err", 32'(err1), 32'd2);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_state", 32'(st1), 32'(IDLE));
        check("abort_date", {if1.calc_month, if1.calc_dayOfMonth}, {4'd1, 6'd1});
        check("abort_flags", {busy1, done1, fev1, err1, fed1}, 32'd0);
        run_sweep(1'b0, 1'b0, 0, 1'b0, "after_abort");

        run_sweep(1'b1, 1'b0, 0, 1'b0, "settle3");
        for (int d = 1; d <= 366; d++) bad[d] = ($urandom_range(0, 29) == 0);
        run_sweep(1'b1, 1'b1, 2, 1'b1, "settle3_rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/day_calc_sequencer.md
DAY_CALC_SEQUENCER -- requirements
Module: day_calc_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, meaning: cycles a date is held on the calculator inputs before its result is sampled (legal range 1..15).
REQ-002 clk  input  1  meaning: single clock; every flop is clocked on its rising edge.
REQ-003 reset  input  1  meaning: reset, synchronous and active-high.
REQ-004 start  input  1  meaning: one-cycle request to sweep a full year; honoured only in IDLE or DONE.
REQ-005 leap_year  input  1  meaning: year type for the sweep; sampled only on an accepted start.
REQ-006 calc_dayOfMonth  output  6  meaning: drives the calculator dayOfMonth input, range 1..31.
REQ-007 calc_month  output  4  meaning: drives the calculator month input, range 1..12.
REQ-008 calc_dayOfYear  input  9  meaning: calculator result, range 1..366.
REQ-009 busy  output  1  meaning: sweep in progress.
REQ-010 done  output  1  meaning: sweep complete; held high until the next accepted start or reset.
REQ-011 error_count  output  9  meaning: number of mismatching dates in the current or last sweep.
REQ-012 first_err_valid  output  1  meaning: at least one mismatch has occurred.
REQ-013 first_err_day  output  9  meaning: expected day-of-year of the first mismatch.

Function
REQ-014 FSM states SHALL be IDLE, SETTLE, CHECK and DONE.
REQ-015 An accepted start in IDLE or DONE SHALL perform these actions at that edge:
- calc_month=1, calc_dayOfMonth=1, expected=1;
- error_count=0, first_err_valid=0, first_err_day=0;
- latch leap_year, clear done;
- go to SETTLE.
REQ-016 SETTLE SHALL last exactly SETTLE_CYCLES cycles (4-bit down-counter), then go to CHECK.
REQ-017 CHECK SHALL last one cycle and compare calc_dayOfYear with the 9-bit expected counter.
REQ-018 A mismatch in CHECK SHALL increment error_count (saturating at 511). If it is the first mismatch, CHECK SHALL also load first_err_day=expected and set first_err_valid.
REQ-019 At the CHECK edge, when the current date is not the last date, the next date SHALL be applied:
- expected increments;
- calc_dayOfMonth increments;
- when calc_dayOfMonth equals the month length: calc_dayOfMonth=1 and calc_month increments;
- the FSM returns to SETTLE.
REQ-020 Month lengths SHALL be 31,28,31,30,31,30,31,31,30,31,30,31; February SHALL be 29 when the latched leap flag is 1.
REQ-021 When CHECK completes 12/31, the FSM SHALL go to DONE with busy=0 and done=1, and the date outputs SHALL hold 12/31.
REQ-022 busy SHALL be 1 exactly in SETTLE and CHECK.
REQ-023 Cycles from the accepted-start edge to done rising SHALL equal N*(SETTLE_CYCLES+1), where N=365 for a normal year and N=366 for a leap year.
REQ-024 start SHALL be ignored while busy=1, and leap_year changes mid-sweep SHALL have no effect.
REQ-025 A start coincident with the final CHECK SHALL be ignored; the FSM SHALL enter DONE.
REQ-026 calc_month and calc_dayOfMonth SHALL change only at CHECK edges or an accepted start, so the calculator inputs are stable throughout each SETTLE window.

Reset
REQ-027 When reset=1 at a clock edge, the block SHALL enter IDLE and set:
- calc_month=1, calc_dayOfMonth=1, expected=1;
- busy=0, done=0;
- error_count=0, first_err_valid=0, first_err_day=0;
- leap latch=0, settle counter=0.
REQ-028 Reset SHALL take priority over start and SHALL abort a sweep in any state.
REQ-029 Outputs SHALL not change asynchronously with reset.

Structure
REQ-030 Package day_calc_pkg SHALL hold:
- the state enum type;
- width constants: DAY_W=6, MONTH_W=4, DOY_W=9;
- the 12-entry non-leap month-length table.
REQ-031 Sub-module month_length_lut SHALL map (month[3:0], leap) to length[5:0] combinationally, and SHALL return 0 for month values 0 and 13..15.
REQ-032 The calculator SHALL be instantiated outside this block; the sequencer connects only to its ports.

Verification
REQ-033 Scenario: leap_year=0, correct calculator, SETTLE_CYCLES=1 -> done rises 730 cycles after start; error_count=0; first_err_valid=0; final outputs 12/31.
REQ-034 Scenario: leap_year=1, calculator with the same leap flag -> 366 CHECK cycles; 2/29 presented; error_count=0; done after 732 cycles.
REQ-035 Scenario: leap_year=1, calculator fixed to non-leap -> first mismatch at 3/1; first_err_day=61; error_count=306.
REQ-036 Scenario: start pulsed again during the sweep, and leap_year toggled mid-sweep -> no restart; totals identical to REQ-033.
REQ-037 Scenario: reset asserted one cycle while on 6/15 -> next cycle IDLE, outputs 1/1, busy=0, error_count=0. A new start then completes normally.
REQ-038 Scenario: SETTLE_CYCLES=3 -> inputs stable for 4-cycle windows; done after 1460 cycles for leap_year=0.
